// File: rtl/sensor_command_controller.sv
`default_nettype none
// ============================================================================
//  Module   : sensor_command_controller
//  Purpose  : Host command FSM for NUM_SENSORS DHT11-class channels with
//             periodic continuous monitoring, timeout and checksum checking.
//  Revision : 1.0 - initial release
// ============================================================================
module sensor_command_controller #(
  parameter int NUM_SENSORS = 32,
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int PERIOD_CYC  = 100_000_000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_code,
  input  logic [7:0]  cmd_addr,
  output logic        cmd_ready,
  output logic        sensor_start,
  output logic [7:0]  sensor_sel,
  input  logic        sensor_done,
  input  logic        sensor_error,
  input  logic [39:0] sensor_data,
  output logic        tx_valid,
  output logic [7:0]  tx_code,
  output logic [15:0] tx_data,
  input  logic        tx_ready,
  output logic        busy
);

  localparam int MASK_W = 2 * NUM_SENSORS;
  localparam int TMR_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int PER_W  = $clog2(PERIOD_CYC + 1);

  localparam logic [7:0] c_cmd_status    = 8'h01;
  localparam logic [7:0] c_cmd_read_temp = 8'h02;
  localparam logic [7:0] c_cmd_read_hum  = 8'h03;
  localparam logic [7:0] c_cmd_loop_temp = 8'h04;
  localparam logic [7:0] c_cmd_loop_hum  = 8'h05;
  localparam logic [7:0] c_cmd_stop_temp = 8'h06;
  localparam logic [7:0] c_cmd_stop_hum  = 8'h07;

  localparam logic [7:0] c_rsp_ok        = 8'h07;
  localparam logic [7:0] c_rsp_hum       = 8'h08;
  localparam logic [7:0] c_rsp_temp      = 8'h09;
  localparam logic [7:0] c_rsp_stop_temp = 8'h0A;
  localparam logic [7:0] c_rsp_stop_hum  = 8'h0B;
  localparam logic [7:0] c_rsp_fault     = 8'h1F;
  localparam logic [7:0] c_rsp_bad_cmd   = 8'hCF;
  localparam logic [7:0] c_rsp_bad_addr  = 8'hEF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_EVAL  = 3'd4,
    ST_SEND  = 3'd5
  } state_t;

  state_t              r_state;
  logic [7:0]          r_code;
  logic [7:0]          r_addr;
  logic [39:0]         r_data;
  logic                r_err;
  logic                r_timeout;
  logic [TMR_W-1:0]    r_wait_cnt;
  logic [PER_W-1:0]    r_period_cnt;
  logic [MASK_W-1:0]   r_loop_mask;
  logic [MASK_W-1:0]   r_pending;

  logic [8:0]          w_take_idx;
  logic [MASK_W-1:0]   w_take_onehot;
  logic [MASK_W-1:0]   w_take_clr;
  logic [MASK_W-1:0]   w_chk_onehot;
  logic [MASK_W-1:0]   w_stop_clr;
  logic [MASK_W-1:0]   w_start_set;
  logic [MASK_W-1:0]   w_mask_next;
  logic [MASK_W-1:0]   w_pend_next;
  logic                w_wrap;
  logic                w_chk_hum;
  logic                w_code_ok;
  logic                w_addr_ok;
  logic                w_cks_ok;
  logic [7:0]          w_cks_sum;

  // Mask bit 2*ch is the temperature loop, 2*ch+1 the humidity loop.
  always_comb begin
    w_take_idx = '0;
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (r_pending[i]) w_take_idx = 9'(i);
    end
  end

  assign w_take_onehot = r_pending & (~r_pending + MASK_W'(1));
  assign w_take_clr    = (r_state == ST_IDLE && !(cmd_valid && cmd_ready)) ? w_take_onehot : '0;

  assign w_code_ok    = (r_code != 8'd0) && (r_code <= 8'd7);
  assign w_addr_ok    = int'(r_addr) < NUM_SENSORS;
  assign w_chk_hum    = (r_code == c_cmd_read_hum) || (r_code == c_cmd_loop_hum) ||
                        (r_code == c_cmd_stop_hum);
  assign w_chk_onehot = MASK_W'(1) << {r_addr, w_chk_hum};

  assign w_stop_clr  = (r_state == ST_CHECK && w_code_ok && w_addr_ok &&
                        (r_code == c_cmd_stop_temp || r_code == c_cmd_stop_hum)) ? w_chk_onehot : '0;
  assign w_start_set = (r_state == ST_CHECK && w_code_ok && w_addr_ok &&
                        (r_code == c_cmd_loop_temp || r_code == c_cmd_loop_hum)) ? w_chk_onehot : '0;

  assign w_wrap      = (r_period_cnt == PER_W'(PERIOD_CYC - 1));
  assign w_mask_next = (r_loop_mask | w_start_set) & ~w_stop_clr;
  // A stop in the wrap cycle must not re-arm its own bit; a taken bit may re-arm.
  assign w_pend_next = (r_pending & ~w_take_clr & ~w_stop_clr) |
                       (w_wrap ? (r_loop_mask & ~w_stop_clr) : '0);

  assign w_cks_sum = r_data[39:32] + r_data[31:24] + r_data[23:16] + r_data[15:8];
  assign w_cks_ok  = (w_cks_sum == r_data[7:0]);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_code       <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_err        <= 1'b0;
      r_timeout    <= 1'b0;
      r_wait_cnt   <= '0;
      r_period_cnt <= '0;
      r_loop_mask  <= '0;
      r_pending    <= '0;
      cmd_ready    <= 1'b0;
      sensor_start <= 1'b0;
      sensor_sel   <= '0;
      tx_valid     <= 1'b0;
      tx_code      <= '0;
      tx_data      <= '0;
      busy         <= 1'b0;
    end else begin
      r_period_cnt <= w_wrap ? '0 : r_period_cnt + PER_W'(1);
      r_loop_mask  <= w_mask_next;
      r_pending    <= w_pend_next;
      sensor_start <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            r_code    <= cmd_code;
            r_addr    <= cmd_addr;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            r_state   <= ST_CHECK;
          end else if (|r_pending) begin
            r_code       <= w_take_idx[0] ? c_cmd_read_hum : c_cmd_read_temp;
            r_addr       <= w_take_idx[8:1];
            sensor_sel   <= w_take_idx[8:1];
            sensor_start <= 1'b1;
            cmd_ready    <= 1'b0;
            busy         <= 1'b1;
            r_state      <= ST_START;
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        ST_CHECK: begin
          if (!w_code_ok) begin
            tx_valid <= 1'b1;
            tx_code  <= c_rsp_bad_cmd;
            tx_data  <= '0;
            r_state  <= ST_SEND;
          end else if (!w_addr_ok) begin
            tx_valid <= 1'b1;
            tx_code  <= c_rsp_bad_addr;
            tx_data  <= {8'h00, r_addr};
            r_state  <= ST_SEND;
          end else if (r_code == c_cmd_stop_temp || r_code == c_cmd_stop_hum) begin
            tx_valid <= 1'b1;
            tx_code  <= (r_code == c_cmd_stop_temp) ? c_rsp_stop_temp : c_rsp_stop_hum;
            tx_data  <= '0;
            r_state  <= ST_SEND;
          end else begin
            sensor_sel   <= r_addr;
            sensor_start <= 1'b1;
            r_state      <= ST_START;
          end
        end

        ST_START: begin
          r_wait_cnt <= '0;
          r_state    <= ST_WAIT;
        end

        ST_WAIT: begin
          if (sensor_done) begin
            r_data    <= sensor_data;
            r_err     <= sensor_error;
            r_timeout <= 1'b0;
            r_state   <= ST_EVAL;
          end else if (r_wait_cnt == TMR_W'(TIMEOUT_CYC - 1)) begin
            r_err     <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= ST_EVAL;
          end else begin
            r_wait_cnt <= r_wait_cnt + TMR_W'(1);
          end
        end

        ST_EVAL: begin
          tx_valid <= 1'b1;
          tx_data  <= '0;
          r_state  <= ST_SEND;
          if (r_err || r_timeout || !w_cks_ok) begin
            tx_code <= c_rsp_fault;
          end else if (r_code == c_cmd_status) begin
            tx_code <= c_rsp_ok;
          end else if (w_chk_hum) begin
            tx_code <= c_rsp_hum;
            tx_data <= r_data[39:24];
          end else begin
            tx_code <= c_rsp_temp;
            tx_data <= r_data[23:8];
          end
        end

        ST_SEND: begin
          if (tx_ready) begin
            tx_valid  <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sensor_command_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sensor_command_controller
//  Purpose  : Scoreboard bench for sensor_command_controller.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sensor_command_controller;

  localparam int NUM_SENSORS = 32;
  localparam int TIMEOUT_CYC = 200;
  localparam int PERIOD_CYC  = 1000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_code = '0;
  logic [7:0]  cmd_addr = '0;
  logic        cmd_ready;
  logic        sensor_start;
  logic [7:0]  sensor_sel;
  logic        sensor_done = 1'b0;
  logic        sensor_error = 1'b0;
  logic [39:0] sensor_data = '0;
  logic        tx_valid;
  logic [7:0]  tx_code;
  logic [15:0] tx_data;
  logic        tx_ready = 1'b0;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];

  bit          sens_hang = 1'b0;
  bit          sens_chan = 1'b0;
  bit          sens_err  = 1'b0;
  int          sens_delay = 10;
  logic [39:0] sens_val = '0;

  sensor_command_controller #(
    .NUM_SENSORS (NUM_SENSORS),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .PERIOD_CYC  (PERIOD_CYC)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .cmd_valid    (cmd_valid),
    .cmd_code     (cmd_code),
    .cmd_addr     (cmd_addr),
    .cmd_ready    (cmd_ready),
    .sensor_start (sensor_start),
    .sensor_sel   (sensor_sel),
    .sensor_done  (sensor_done),
    .sensor_error (sensor_error),
    .sensor_data  (sensor_data),
    .tx_valid     (tx_valid),
    .tx_code      (tx_code),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [39:0] with_cks(input logic [31:0] b);
    logic [7:0] s;
    s = b[31:24] + b[23:16] + b[15:8] + b[7:0];
    return {b, s};
  endfunction

  // Per-channel word: hum = {40|ch, 01}, temp = {20|ch, 02}
  function automatic logic [39:0] chan_word(input logic [7:0] ch);
    return with_cks({8'h40 | ch, 8'h01, 8'h20 | ch, 8'h02});
  endfunction

  initial begin : sensor_model
    logic [7:0] ch;
    forever begin
      @(negedge clock);
      sensor_done = 1'b0;
      if (sensor_start && !sens_hang) begin
        ch = sensor_sel;
        repeat (sens_delay) @(negedge clock);
        sensor_data  = sens_chan ? chan_word(ch) : sens_val;
        sensor_error = sens_err;
        sensor_done  = 1'b1;
      end
    end
  end

  task automatic send_cmd(input logic [7:0] code, input logic [7:0] addr, output bit ok);
    int n = 0;
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_code  = code;
    cmd_addr  = addr;
    while (!cmd_ready && n < 5000) begin
      @(negedge clock);
      n++;
    end
    ok = cmd_ready;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_tx(input int limit, output int cyc, output bit ok);
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!tx_valid && cyc < limit);
    ok = tx_valid;
  endtask

  task automatic take_tx(output logic [7:0] code, output logic [15:0] data);
    code = tx_code;
    data = tx_data;
    tx_ready = 1'b1;
    @(posedge clock);
    #1;
    tx_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({cmd_ready, sensor_start, sensor_sel, tx_valid, tx_code, tx_data, busy} !== 36'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0",
               {cmd_ready, sensor_start, sensor_sel, tx_valid, tx_code, tx_data, busy});
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: got %b want 0", cmd_ready);
    end
    @(negedge clock);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_edge: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_read_temp();
    bit ok;
    int cyc;
    logic [7:0] c;
    logic [15:0] d;
    logic [23:0] e;
    sens_chan = 1'b0; sens_err = 1'b0; sens_delay = 10;
    sens_val = 40'h37_00_19_05_55;
    exp_q.push_back({8'h09, 16'h1905});
    send_cmd(8'h02, 8'd3, ok);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      checks++;
      if (sensor_start !== (k == 2) || (k == 2 && sensor_sel !== 8'd3)) begin
        errors++;
        $display("FAIL start_pulse cycle %0d: got start=%b sel=%0d want start=%b sel=3",
                 k, sensor_start, sensor_sel, (k == 2));
      end
    end
    wait_tx(100, cyc, ok);
    // done visible in cycle 12 -> tx_valid in cycle 14
    checks++;
    if (!ok || cyc + 3 !== 14) begin
      errors++;
      $display("FAIL read_latency: got cycle %0d valid=%b want cycle 14", cyc + 3, ok);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      checks++;
      if ({tx_valid, tx_code, tx_data} !== {1'b1, exp_q[0]}) begin
        errors++;
        $display("FAIL hold_stable: got %b/%h/%h want 1/%h", tx_valid, tx_code, tx_data, exp_q[0]);
      end
    end
    take_tx(c, d);
    e = exp_q.pop_front();
    checks++;
    if ({c, d} !== e) begin
      errors++;
      $display("FAIL read_temp: got %h/%h want %h", c, d, e);
    end
  endtask

  task automatic test_invalid();
    logic [39:0] tbl [7] = '{40'h09_00_CF_0000, 40'h01_28_EF_0028, 40'h00_28_CF_0000,
                             40'h08_00_CF_0000, 40'h02_20_EF_0020, 40'h06_01_0A_0000,
                             40'h07_05_0B_0000};
    bit ok;
    int cyc;
    logic [7:0] c;
    logic [15:0] d;
    logic [23:0] e;
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(tbl[i][23:0]);
      send_cmd(tbl[i][39:32], tbl[i][31:24], ok);
      wait_tx(50, cyc, ok);
      checks++;
      if (!ok || cyc !== 2) begin
        errors++;
        $display("FAIL invalid_latency[%0d]: got cycle %0d valid=%b want cycle 2", i, cyc, ok);
      end
      take_tx(c, d);
      e = exp_q.pop_front();
      checks++;
      if ({c, d} !== e) begin
        errors++;
        $display("FAIL invalid_resp[%0d]: got %h/%h want %h", i, c, d, e);
      end
    end
  endtask

  task automatic test_sensor_faults();
    logic [40:0] vals [5] = '{{1'b0, 40'h37_00_19_05_55}, {1'b0, 40'h37_00_19_05_55},
                              {1'b0, 40'h37_00_19_05_54}, {1'b1, 40'h37_00_19_05_55},
                              {1'b0, 40'h12_34_56_78_14}};
    logic [39:0] tbl [5] = '{40'h01_00_07_0000, 40'h03_1F_08_3700, 40'h03_02_1F_0000,
                             40'h02_02_1F_0000, 40'h02_07_09_5678};
    bit ok;
    int cyc;
    logic [7:0] c;
    logic [15:0] d;
    logic [23:0] e;
    sens_chan = 1'b0; sens_delay = 4;
    for (int i = 0; i < 5; i++) begin
      sens_err = vals[i][40];
      sens_val = vals[i][39:0];
      exp_q.push_back(tbl[i][23:0]);
      send_cmd(tbl[i][39:32], tbl[i][31:24], ok);
      wait_tx(100, cyc, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL sensor_resp_timeout[%0d]: got valid=0 want 1", i);
      end
      take_tx(c, d);
      e = exp_q.pop_front();
      checks++;
      if ({c, d} !== e) begin
        errors++;
        $display("FAIL sensor_resp[%0d]: got %h/%h want %h", i, c, d, e);
      end
    end
    sens_err = 1'b0;
  endtask

  task automatic test_timeout();
    bit ok;
    int cyc;
    logic [7:0] c;
    logic [15:0] d;
    logic [23:0] e;
    sens_hang = 1'b1;
    exp_q.push_back({8'h1F, 16'h0000});
    send_cmd(8'h02, 8'd5, ok);
    wait_tx(TIMEOUT_CYC + 100, cyc, ok);
    // WAIT entered at cycle 3, EVAL at 3+TIMEOUT_CYC, SEND one cycle later
    checks++;
    if (!ok || cyc !== TIMEOUT_CYC + 4) begin
      errors++;
      $display("FAIL timeout_latency: got cycle %0d valid=%b want cycle %0d", cyc, ok, TIMEOUT_CYC + 4);
    end
    take_tx(c, d);
    e = exp_q.pop_front();
    checks++;
    if ({c, d} !== e) begin
      errors++;
      $display("FAIL timeout_resp: got %h/%h want %h", c, d, e);
    end
    sens_hang = 1'b0;
  endtask

  task automatic test_loop();
    // {has_cmd, code, addr, exp_code, exp_data}
    logic [40:0] steps [9] = '{{1'b1, 40'h04_01_09_2102}, {1'b1, 40'h05_02_08_4201},
                               {1'b0, 40'h00_00_09_2102}, {1'b0, 40'h00_00_08_4201},
                               {1'b0, 40'h00_00_09_2102}, {1'b0, 40'h00_00_08_4201},
                               {1'b1, 40'h06_01_0A_0000}, {1'b0, 40'h00_00_08_4201},
                               {1'b0, 40'h00_00_08_4201}};
    bit ok;
    int cyc;
    logic [7:0] c;
    logic [15:0] d;
    logic [23:0] e;
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    sens_chan = 1'b1; sens_delay = 5;
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(steps[i][23:0]);
      if (steps[i][40]) begin
        send_cmd(steps[i][39:32], steps[i][31:24], ok);
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL loop_cmd_accept[%0d]: got ready=0 want 1", i);
        end
      end
      wait_tx(PERIOD_CYC * 3, cyc, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL loop_resp_timeout[%0d]: got valid=0 want 1", i);
      end
      take_tx(c, d);
      e = exp_q.pop_front();
      checks++;
      if ({c, d} !== e) begin
        errors++;
        $display("FAIL loop_resp[%0d]: got %h/%h want %h", i, c, d, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int cyc;
    int n;
    logic [7:0] c;
    logic [15:0] d;
    logic [23:0] e;
    exp_q.push_back({8'h07, 16'h0000});
    send_cmd(8'h01, 8'd0, ok);
    wait_tx(100, cyc, ok);
    // Hold the response past a period wrap so the ch2 humidity loop is pending
    repeat (PERIOD_CYC + 100) @(negedge clock);
    checks++;
    if ({tx_valid, tx_code, tx_data} !== {1'b1, exp_q[0]}) begin
      errors++;
      $display("FAIL long_hold: got %b/%h/%h want 1/%h", tx_valid, tx_code, tx_data, exp_q[0]);
    end
    cmd_valid = 1'b1;
    cmd_code  = 8'h03;
    cmd_addr  = 8'd4;
    exp_q.push_back({8'h08, 16'h4401});
    exp_q.push_back({8'h08, 16'h4201});
    take_tx(c, d);
    e = exp_q.pop_front();
    checks++;
    if ({c, d} !== e) begin
      errors++;
      $display("FAIL held_resp: got %h/%h want %h", c, d, e);
    end
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL host_ready: got %b want 1", cmd_ready);
    end
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wait_tx(PERIOD_CYC * 2, cyc, ok);
      take_tx(c, d);
      e = exp_q.pop_front();
      checks++;
      if (!ok || {c, d} !== e) begin
        errors++;
        $display("FAIL arbitration[%0d]: got %h/%h valid=%b want %h", i, c, d, ok, e);
      end
    end
  endtask

  task automatic test_reset_midflight();
    bit ok;
    int seen = 0;
    sens_hang = 1'b1;
    send_cmd(8'h02, 8'd0, ok);
    repeat (5) @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_wait: got %b want 1", busy);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, sensor_start, sensor_sel, tx_valid, tx_code, tx_data, busy} !== 36'd0) begin
      errors++;
      $display("FAIL async_reset: got %h want 0",
               {cmd_ready, sensor_start, sensor_sel, tx_valid, tx_code, tx_data, busy});
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    sens_hang = 1'b0;
    // ch2 humidity loop was armed; after reset no read or response may appear
    repeat (PERIOD_CYC + 200) begin
      @(negedge clock);
      if (tx_valid || sensor_start) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL post_reset_quiet: got %0d active cycles want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_read_temp();
    test_invalid();
    test_sensor_faults();
    test_timeout();
    test_loop();
    test_back_to_back();
    test_reset_midflight();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
